button_conditioner: RTL

- Conditions the raw push-button inputs that drive the sequencer's Run, Continue and ContinueIR inputs.
- Each channel gets a two-flop synchronizer, a debounce FSM and a single-cycle press pulse.
- A held button therefore advances the sequencer exactly once: one instruction per Continue press, one start per Run press.
- Sits between the board pushbuttons and the control unit, in the same Clk domain.

---
 rtl/button_conditioner.sv | 93 +++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-button two-flop synchronizer, debounce FSM and single-cycle press pulse
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW = 1,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_btn,
  input  logic       Continue_btn,
  input  logic       ContinueIR_btn,
  output logic       Run,
  output logic       Continue,
  output logic       ContinueIR,
  output logic [2:0] Btn_held
);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic REL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [2:0] btn, pulse;
  assign btn = {ContinueIR_btn, Continue_btn, Run_btn};
  for (genvar g = 0; g < 3; g++) begin : ch
    logic s1_q, s1_d, s2_q, s2_d, p;
    logic pulse_q, pulse_d, held_q, held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t state_q, state_d;
    // synchronizer shift and pressed-polarity mapping
    always_comb begin
      s1_d = btn[g];
      s2_d = s1_q;
      p = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;
    end
    // debounce next state; pulse only on the accepted press
    always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
        RELEASED: if (p) begin
          state_d = PRESS_WAIT;
          cnt_d = '0;
        end
        PRESS_WAIT: if (!p) begin
          state_d = RELEASED;
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = PRESSED;
          cnt_d = '0;
          pulse_d = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
        PRESSED: if (!p) begin
          state_d = RELEASE_WAIT;
          cnt_d = '0;
        end
        RELEASE_WAIT: if (p) begin
          state_d = PRESSED;
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = RELEASED;
          cnt_d = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
        default: begin
          state_d = RELEASED;
          cnt_d = '0;
        end
      endcase
      held_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end
    // channel state registers, reset to released
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        s1_q <= REL;
        s2_q <= REL;
        state_q <= RELEASED;
        cnt_q <= '0;
        pulse_q <= 1'b0;
        held_q <= 1'b0;
      end else begin
        s1_q <= s1_d;
        s2_q <= s2_d;
        state_q <= state_d;
        cnt_q <= cnt_d;
        pulse_q <= pulse_d;
        held_q <= held_d;
      end
    end
    assign pulse[g] = pulse_q;
    assign Btn_held[g] = held_q;
  end
  assign Run = pulse[0];
  assign Continue = pulse[1];
  assign ContinueIR = pulse[2];
endmodule
